hamming74_encoder: RTL and testbench
====================================

// Module: hamming74_encoder
// PURPOSE
//   Hamming(7,4) encoder: the transmit end of the 7-bit code link checked by decoder_proj.
//   Accepts 4-bit nibbles on a valid/ready handshake, buffers them in a small FIFO, and emits
//   codewords in the io_in bit layout. Output is either a parallel word (valid/ready) or an
//   LSB-first serial frame. Optional single-bit error injection drives decoder verification.
// PARAMETERS
//   FIFO_DEPTH  2   codeword FIFO entries; power of two, >= 2
//   CNT_W       8   width of code_count
// PORTS
//   clock       in   1      sole clock; all state changes on posedge
//   reset_n     in   1      asynchronous, active-low reset
//   in_valid    in   1      nibble offered
//   in_ready    out  1      encoder can accept (FIFO not full)
//   in_data     in   4      nibble: d1=in_data[0] .. d4=in_data[3]
//   inject_pos  in   3      0 = no error; 1..7 = invert codeword position k (bit k-1)
//   ser_en      in   1      1 = serial output mode, 0 = parallel mode
//   par_valid   out  1      par_code holds a codeword (parallel mode only)
//   par_ready   in   1      sink takes par_code
//   par_code    out  7      codeword at FIFO head
//   ser_data    out  1      serial bit, LSB (position 1) first
//   ser_frame   out  1      high during the first bit of each serial frame
//   ser_busy    out  1      serializer in SHIFT
//   code_count  out  CNT_W  codewords emitted (either mode), wraps
// BEHAVIOUR
//   Reset (async assert, sync-to-clock deassert handled upstream): FIFO empty, FSM IDLE,
//     in_ready=1, par_valid=0, par_code=0, ser_data=0, ser_frame=0, ser_busy=0, code_count=0.
//     Reset mid-frame or mid-transfer drops all buffered and in-flight codewords immediately.
//   Encoding (on push): p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4;
//     code[6:0] = {d4,d3,d2,p3,d1,p2,p1}; if inject_pos!=0, code[inject_pos-1] inverted.
//     inject_pos is sampled with in_data in the accepting cycle.
//   Input: push on in_valid && in_ready; in_ready = !full. No push while full; in_data held
//     by the source until accepted.
//   Parallel mode (ser_en=0 and FSM IDLE): par_valid = !empty; par_code = FIFO head.
//     Pop on par_valid && par_ready. Nibble accepted at edge N -> par_valid=1 after edge N.
//     Push and pop in the same cycle are both performed (count unchanged).
//   par_code shows the head whenever FIFO non-empty, 0 when empty.
//   Serial FSM: IDLE -> SHIFT when ser_en=1 && !empty: load head into shreg, pop, bit_cnt=0.
//     SHIFT: ser_data=shreg[bit_cnt], ser_frame=(bit_cnt==0), ser_busy=1; bit_cnt++ per cycle.
//     At bit_cnt==6: if ser_en && !empty, load next head (back-to-back frame, no gap cycle),
//     else -> IDLE. Each frame is exactly 7 cycles.
//   ser_en is honoured only at frame boundaries; toggling mid-frame never truncates a frame.
//   While FSM in SHIFT or ser_en=1, par_valid=0. In IDLE, ser_data=0, ser_frame=0.
//   code_count += 1 on every pop (parallel handshake or serial load); wraps max -> 0.
//   FIFO pointers wrap modulo FIFO_DEPTH; full/empty distinguished by an occupancy count.
// TESTING
//   1 Parallel: push 4'hB, par_ready=1 -> par_code=7'b1010101 one cycle later, code_count=1.
//   2 Injection: push 4'hF, inject_pos=4 -> par_code=7'b1110111 (p3 flipped); 4'h0,
//     inject_pos=0 -> 7'b0000000; 4'h1 -> 7'b0000111.
//   3 Backpressure: par_ready=0, push 3 nibbles (FIFO_DEPTH=2) -> in_ready=0 after 2nd,
//     3rd held; release par_ready -> words emerge in order, none lost or duplicated.
//   4 Serial: ser_en=1, push 4'hB then 4'h1 -> ser_data 1,0,1,0,1,0,1 then 1,1,1,0,0,0,0
//     over 14 contiguous cycles, ser_frame high on cycles 0 and 7, ser_busy low after.
//   5 Mode switch: drop ser_en at bit 3 of a frame -> frame completes all 7 bits, then
//     par_valid rises for the next buffered word.
//   6 Reset: assert reset_n=0 mid-frame with 2 words buffered -> all outputs at reset values
//     without a clock edge; after release, code_count=0 and first new word encodes correctly;
//     256 pops wrap code_count to 0.

Source files
------------

// File: rtl/hamming74_encoder.sv
// Hamming(7,4) encoder with a small codeword FIFO. Codewords leave either as a parallel
// word on a valid/ready port or as an LSB-first 7-bit serial frame.
module hamming74_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic [2:0]       inject_pos,
  input  logic             ser_en,
  output logic             par_valid,
  input  logic             par_ready,
  output logic [6:0]       par_code,
  output logic             ser_data,
  output logic             ser_frame,
  output logic             ser_busy,
  output logic [CNT_W-1:0] code_count,
  output logic             dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [6:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic               full, empty;
  logic               push, pop, par_pop, ser_load;
  logic [6:0]         shreg;
  logic [2:0]         bit_cnt;
  logic [6:0]         head;

  // Code layout {d4,d3,d2,p3,d1,p2,p1}; position k (1..7) maps to bit k-1.
  function automatic logic [6:0] encode(input logic [3:0] d, input logic [2:0] inj);
    logic [6:0] c;
    logic [7:0] mask;
    c    = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    mask = (8'd1 << inj) >> 1;
    return c ^ mask[6:0];
  endfunction

  // Handshakes: a transfer happens on a rising clock edge where valid && ready are both high;
  // valid never depends on ready, and the offered data is held stable until it is taken.
  assign full      = (occ == OCC_W'(FIFO_DEPTH));
  assign empty     = (occ == '0);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr];
  assign par_code  = empty ? 7'd0 : head;
  assign par_valid = (state_q == IDLE) && !ser_en && !empty;
  assign par_pop   = par_valid && par_ready;
  assign pop       = par_pop || ser_load;

  always_comb begin
    state_d  = state_q;
    ser_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (ser_en && !empty) begin
          ser_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // ser_en is only looked at on the last bit, so frames are never cut short.
        if (bit_cnt == 3'd6) begin
          if (ser_en && !empty) ser_load = 1'b1;
          else                  state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      code_count <= '0;
    end else begin
      state_q <= state_d;
      if (ser_load) begin
        shreg   <= head;
        bit_cnt <= 3'd0;
      end else if (state_q == SHIFT) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        code_count <= code_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= encode(in_data, inject_pos);
  end

  assign ser_busy  = (state_q == SHIFT);
  assign ser_data  = (state_q == SHIFT) ? shreg[bit_cnt] : 1'b0;
  assign ser_frame = (state_q == SHIFT) && (bit_cnt == 3'd0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hamming74_encoder.sv
// Directed bench for hamming74_encoder: parallel, injection, backpressure, serial framing,
// mode switching, asynchronous reset and code_count wrap.
module tb_hamming74_encoder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic [2:0] inject_pos = 3'd0;
  logic       ser_en = 1'b0;
  logic       par_valid;
  logic       par_ready = 1'b0;
  logic [6:0] par_code;
  logic       ser_data;
  logic       ser_frame;
  logic       ser_busy;
  logic [7:0] code_count;
  logic       dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  logic [6:0] exp_bits;

  hamming74_encoder #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .inject_pos (inject_pos),
    .ser_en     (ser_en),
    .par_valid  (par_valid),
    .par_ready  (par_ready),
    .par_code   (par_code),
    .ser_data   (ser_data),
    .ser_frame  (ser_frame),
    .ser_busy   (ser_busy),
    .code_count (code_count),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offers one nibble and returns #1 after the edge that accepted it.
  task automatic push(input logic [3:0] d, input logic [2:0] inj);
    bit done;
    done       = 1'b0;
    in_valid   = 1'b1;
    in_data    = d;
    inject_pos = inj;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid   = 1'b0;
    inject_pos = 3'd0;
    check("push_accepted", 32'(done), 32'd1);
  endtask

  task automatic pop_one();
    par_ready = 1'b1;
    tick();
    par_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd1);
    check({tag, "_par_valid"},  32'(par_valid),  32'd0);
    check({tag, "_par_code"},   32'(par_code),   32'd0);
    check({tag, "_ser_data"},   32'(ser_data),   32'd0);
    check({tag, "_ser_frame"},  32'(ser_frame),  32'd0);
    check({tag, "_ser_busy"},   32'(ser_busy),   32'd0);
    check({tag, "_code_count"}, 32'(code_count), 32'd0);
  endtask

  initial begin
    // Reset
    #2;
    check_reset_outputs("rst_in");
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    check_reset_outputs("rst_out");
    check("rst_state", 32'(dbg_state), 32'd0);

    // 1 Parallel: 4'hB -> 1010101
    par_ready = 1'b1;
    push(4'hB, 3'd0);
    check("par_b_valid", 32'(par_valid), 32'd1);
    check("par_b_code",  32'(par_code),  32'b1010101);
    tick();
    par_ready = 1'b0;
    check("par_b_count", 32'(code_count), 32'd1);
    check("par_b_empty", 32'(par_valid),  32'd0);
    check("par_b_zero",  32'(par_code),   32'd0);

    // 2 Injection and extreme patterns
    push(4'hF, 3'd4);
    check("inj_f_p3", 32'(par_code), 32'b1110111);
    pop_one();
    push(4'h0, 3'd0);
    check("enc_0", 32'(par_code), 32'b0000000);
    check("enc_0_valid", 32'(par_valid), 32'd1);
    pop_one();
    push(4'h1, 3'd0);
    check("enc_1", 32'(par_code), 32'b0000111);
    pop_one();
    push(4'h0, 3'd7);
    check("inj_0_pos7", 32'(par_code), 32'b1000000);
    pop_one();
    push(4'hB, 3'd1);
    check("inj_b_pos1", 32'(par_code), 32'b1010100);
    pop_one();
    check("inj_count", 32'(code_count), 32'd6);

    // 3 Backpressure: three nibbles into a two-deep FIFO
    push(4'h2, 3'd0);
    push(4'h3, 3'd0);
    check("bp_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 4'h4;
    tick();
    tick();
    check("bp_held",  32'(in_ready), 32'd0);
    check("bp_head2", 32'(par_code), 32'b0011001);
    par_ready = 1'b1;
    tick();
    check("bp_head3",  32'(par_code), 32'b0011110);
    check("bp_ready",  32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_head4",  32'(par_code), 32'b0101010);
    tick();
    par_ready = 1'b0;
    check("bp_drained", 32'(par_valid),  32'd0);
    check("bp_count",   32'(code_count), 32'd9);

    // 4 Serial: B then 1 as two contiguous frames
    ser_en = 1'b1;
    push(4'hB, 3'd0);
    push(4'h1, 3'd0);
    for (int i = 0; i < 14; i++) begin
      exp_bits = (i < 7) ? 7'b1010101 : 7'b0000111;
      check($sformatf("ser_data_%0d", i),  32'(ser_data),  32'(exp_bits[i % 7]));
      check($sformatf("ser_frame_%0d", i), 32'(ser_frame), 32'((i == 0) || (i == 7)));
      check($sformatf("ser_busy_%0d", i),  32'(ser_busy),  32'd1);
      check($sformatf("ser_parv_%0d", i),  32'(par_valid), 32'd0);
      tick();
    end
    check("ser_idle_busy", 32'(ser_busy),   32'd0);
    check("ser_idle_data", 32'(ser_data),   32'd0);
    check("ser_count",     32'(code_count), 32'd11);

    // 5 Mode switch: drop ser_en at bit 3, frame still completes
    push(4'hA, 3'd0);
    push(4'hC, 3'd0);
    exp_bits = 7'b1010010;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) ser_en = 1'b0;
      check($sformatf("mode_data_%0d", i), 32'(ser_data), 32'(exp_bits[i]));
      check($sformatf("mode_busy_%0d", i), 32'(ser_busy), 32'd1);
      check($sformatf("mode_parv_%0d", i), 32'(par_valid), 32'd0);
      tick();
    end
    check("mode_idle",  32'(ser_busy),  32'd0);
    check("mode_parv",  32'(par_valid), 32'd1);
    check("mode_code",  32'(par_code),  32'b1100001);
    pop_one();
    check("mode_count", 32'(code_count), 32'd13);

    // 6 Reset mid-frame with two words buffered
    ser_en = 1'b1;
    push(4'h7, 3'd0);
    push(4'h8, 3'd0);
    push(4'h9, 3'd0);
    check("rst_pre_full", 32'(in_ready), 32'd0);
    tick();
    check("rst_pre_busy", 32'(ser_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    ser_en = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    check_reset_outputs("rst_after");
    push(4'h5, 3'd0);
    check("rst_new_code", 32'(par_code), 32'b0101101);
    pop_one();
    check("rst_new_count", 32'(code_count), 32'd1);

    // code_count wrap after 256 pops
    par_ready = 1'b1;
    for (int i = 0; i < 255; i++) push(4'(i), 3'd0);
    check("wrap_255", 32'(code_count), 32'd255);
    tick();
    par_ready = 1'b0;
    check("wrap_0", 32'(code_count), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
